// File: rtl/seq_nibble_alu.sv
// rtl/seq_nibble_alu.sv - nibble-serial 32-bit ADD/SUB/AND/XOR unit on one 4-bit CLA slice
// Optional flag logic: SEQ_NIBBLE_ALU_FLAGS_EN (undefined: carry/zero/negative/overflow tied to 0)

// 4-bit carry-lookahead slice providing SUM, bitwise AND and bitwise XOR.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic [3:0] band,
  output logic [3:0] bxor,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign band = g;
  assign bxor = p;
  assign cout = c[4];
endmodule

module seq_nibble_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic             cy;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_nxt;

  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic [3:0]       sl_sum;
  logic [3:0]       sl_and;
  logic [3:0]       sl_xor;
  logic [3:0]       sl_out;
  logic             sl_cout;
  logic             accept;
  logic             last;

  assign accept = in_valid && in_ready;
  assign last   = (state == ST_RUN) && (idx == IW'(NIBBLES - 1));

  assign sl_a = a_reg[4*idx +: 4];
  assign sl_b = b_reg[4*idx +: 4];

  cla4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (cy),
    .sum  (sl_sum),
    .band (sl_and),
    .bxor (sl_xor),
    .cout (sl_cout)
  );

  // Pick the slice output for the captured op and splice it into the result word.
  always_comb begin
    sl_out     = sl_sum;
    result_nxt = result;
    case (op_reg)
      2'b10:   sl_out = sl_and;
      2'b11:   sl_out = sl_xor;
      default: sl_out = sl_sum;
    endcase
    result_nxt[4*idx +: 4] = sl_out;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; handshake outputs are pure decodes of the state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture and the nibble-serial datapath; SUB folds into ADD via ~b and carry-in 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      cy     <= 1'b0;
      op_reg <= 2'b00;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
    end else if (accept) begin
      idx    <= '0;
      cy     <= (op == 2'b01);
      op_reg <= op;
      a_reg  <= a;
      b_reg  <= (op == 2'b01) ? ~b : b;
      result <= '0;
    end else if (state == ST_RUN) begin
      result <= result_nxt;
      cy     <= sl_cout;
      if (!last) idx <= idx + IW'(1);
    end
  end

`ifdef SEQ_NIBBLE_ALU_FLAGS_EN
  logic arith;
  assign arith = ~op_reg[1];

  // Flags are captured on the final RUN edge from the fully assembled result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else if (last) begin
      carry    <= arith & sl_cout;
      zero     <= (result_nxt == '0);
      negative <= result_nxt[WIDTH-1];
      overflow <= arith & (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                        & (result_nxt[WIDTH-1] != a_reg[WIDTH-1]);
    end
  end
`else
  assign carry    = 1'b0;
  assign zero     = 1'b0;
  assign negative = 1'b0;
  assign overflow = 1'b0;
`endif
endmodule

// File: doc/seq_nibble_alu.md
# seq_nibble_alu

Multi-cycle 32-bit add/subtract/AND/XOR unit built around a single 4-bit `cla` slice. A controller drives that slice one nibble per clock, LSB first, and chains the carry through a register. It assembles the selected slice output (SUM, BAND or BXOR) into a result word and returns it over a valid/ready handshake. It sits between the execute-stage operand muxes and the writeback path, for area-constrained builds that trade latency for one adder slice.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must be a multiple of 4 and at least 8.
- `NIBBLES`, WIDTH/4 (derived, localparam), cycles spent in RUN.

Ports:
- `clk` input 1, sole clock; all state updates on the rising edge.
- `rst_n` input 1, reset; synchronous, active-low.
- `in_valid` input 1, operand request.
- `in_ready` output 1, high only in IDLE.
- `op` input 2, operation: 00 ADD, 01 SUB, 10 AND, 11 XOR.
- `a` input WIDTH, operand A.
- `b` input WIDTH, operand B.
- `out_valid` output 1, result available; high only in DONE.
- `out_ready` input 1, consumer accepts result.
- `result` output WIDTH, assembled result.
- `carry` output 1, final carry-out (ADD/SUB), else 0.
- `zero` output 1, result == 0.
- `negative` output 1, result[WIDTH-1].
- `overflow` output 1, signed overflow (ADD/SUB), else 0.

## Operation
- Reset (`rst_n`=0 at a rising edge): state is IDLE, the nibble index `idx` is 0, the carry register is 0, and `result`, `carry`, `zero`, `negative`, `overflow` and `out_valid` are 0. Inputs are ignored while `rst_n` is low. After the reset edge, `in_ready`=1.
- IDLE: `in_ready`=1.
  - On `in_valid`&&`in_ready`, the block captures `a`, `b_eff` and `op`.
  - `b_eff` = ~`b` for SUB, otherwise `b`.
  - The carry register is loaded with 1 for SUB, otherwise 0.
  - `idx` is set to 0, `result` is cleared, and the state goes to RUN.
- RUN: the slice is fed A=a_reg[4·idx+:4], B=b_eff[4·idx+:4] and CIN=carry register.
  - Each edge writes result[4·idx+:4] with SUM (ADD/SUB), BAND (AND) or BXOR (XOR).
  - The carry register takes COUT and `idx` increments.
  - On the edge where idx==NIBBLES-1, the state goes to DONE and the flags are registered.
- Flags:
  - `carry` = final COUT for ADD/SUB. For SUB, carry=1 means no borrow (a ≥ b unsigned).
  - `overflow` = (a[MSB]==b_eff[MSB]) && (result[MSB]!=a[MSB]) for ADD/SUB.
  - `carry` and `overflow` are 0 for AND/XOR.
  - `zero` and `negative` are computed from the final result for all ops.
- DONE: `out_valid`=1. `result` and the flags are held stable until `out_valid`&&`out_ready`; then the state goes to IDLE. `in_valid` is ignored in DONE.
- Result and flags stay unchanged in IDLE until the next accept clears `result`.
- Reset asserted in any state aborts the operation at that edge. No `out_valid` is produced for an aborted op.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - The carry register is 1 bit.
  - `idx` is ceil(log2(NIBBLES)) bits and never wraps past NIBBLES-1 (the last RUN edge moves the state to DONE).

## Timing
- Accept edge e0; RUN edges e1…eNIBBLES.
- `out_valid` is visible after edge eNIBBLES (8 cycles after accept for WIDTH=32).
- With `out_ready` held high, the handshake completes at eNIBBLES+1 and the next accept can occur at eNIBBLES+2.
- Minimum period is NIBBLES+2 cycles (10 at WIDTH=32).
- No back-to-back acceptance: `in_ready` is 0 throughout RUN and DONE.
- All outputs are registered, except `in_ready` and `out_valid`, which are pure decodes of the state register.

## Configuration
- `SEQ_NIBBLE_ALU_FLAGS_EN` defined:
  - `carry`, `zero`, `negative` and `overflow` are computed and registered as described above.
- Undefined:
  - The flag logic and its registers are removed.
  - The four flag ports remain and are tied to 0.
  - `result`, handshake and latency are identical to the defined build.

## Test plan
- ADD a=0x0000000F, b=0x00000001 → result 0x00000010, carry 0, zero 0, overflow 0; `out_valid` rises exactly 8 cycles after the accept edge.
- ADD a=0xFFFFFFFF, b=0x00000001 → result 0x00000000, carry 1, zero 1, overflow 0, negative 0.
- SUB a=0x80000000, b=0x00000001 → result 0x7FFFFFFF, carry 1, overflow 1, negative 0. Then SUB 0x00000001−0x00000002 → 0xFFFFFFFF, carry 0, negative 1.
- AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000, negative 1, carry 0. Then XOR of the same operands → 0x0FF00FF0, negative 0.
- Complete an op, then hold `out_ready`=0 for 5 cycles while pulsing `in_valid` → `result` and flags stable, `out_valid`=1, `in_ready`=0, no new capture. Release `out_ready` → IDLE on the next edge.
- Assert `rst_n`=0 for one edge while idx==3 in RUN → next cycle IDLE, `out_valid` 0, `result` 0, `in_ready` 1. A following ADD 0x12345678+0x11111111 → 0x23456789.
